// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: handshake and hazard-information bundle between the datapath and pipe_hazard_ctrl.
// The datapath side uses the master modport; the controller uses slave.
interface pipe_hazard_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic [RA_W-1:0]  id_raddr1, id_raddr2, es_dest, ms_dest, ws_dest;
    logic             id_use1, id_use2, br_taken, es_gr_we, es_res_from_mem;
    logic             ms_gr_we, ws_gr_we, mem_wait;
    logic             pc_we, br_redirect, fs_to_ds_we, ds_to_es_we, es_to_ms_we, ms_to_ws_we;
    logic             ds_valid, es_valid, ms_valid, ws_valid, load_use_stall;
    logic [1:0]       fwd_sel1, fwd_sel2;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  id_raddr1, id_raddr2, id_use1, id_use2, br_taken,
               es_gr_we, es_dest, es_res_from_mem, ms_gr_we, ms_dest,
               ws_gr_we, ws_dest, mem_wait,
        output pc_we, br_redirect, fs_to_ds_we, ds_to_es_we, es_to_ms_we,
               ms_to_ws_we, ds_valid, es_valid, ms_valid, ws_valid,
               fwd_sel1, fwd_sel2, load_use_stall, stall_cnt
    );

    modport master (
        output id_raddr1, id_raddr2, id_use1, id_use2, br_taken,
               es_gr_we, es_dest, es_res_from_mem, ms_gr_we, ms_dest,
               ws_gr_we, ws_dest, mem_wait,
        input  pc_we, br_redirect, fs_to_ds_we, ds_to_es_we, es_to_ms_we,
               ms_to_ws_we, ds_valid, es_valid, ms_valid, ws_valid,
               fwd_sel1, fwd_sel2, load_use_stall, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline valid/allowin control, load-use interlock, RAW forwarding select.
// PIPE_FWD_EN defined enables EX/MEM/WB forwarding; undefined gives a full RAW interlock.
module pipe_hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input logic                  clk,
    input logic                  reset,
    pipe_hazard_ctrl_if.slave    bus
);
    logic             fs_valid_q, ds_valid_q, es_valid_q, ms_valid_q, ws_valid_q;
    logic             fs_valid_d, ds_valid_d, es_valid_d, ms_valid_d, ws_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             hes1, hes2, hms1, hms2, hws1, hws2, stall;
    logic             ds_ready_go, ms_ready_go, ds_allowin, es_allowin, ms_allowin, redirect;

    function automatic logic hit(logic v, logic we, logic [RA_W-1:0] d, logic [RA_W-1:0] a);
        return v & we & (d != '0) & (d == a);
    endfunction

    always_comb begin
        hes1 = bus.id_use1 & hit(es_valid_q, bus.es_gr_we, bus.es_dest, bus.id_raddr1);
        hes2 = bus.id_use2 & hit(es_valid_q, bus.es_gr_we, bus.es_dest, bus.id_raddr2);
        hms1 = bus.id_use1 & hit(ms_valid_q, bus.ms_gr_we, bus.ms_dest, bus.id_raddr1);
        hms2 = bus.id_use2 & hit(ms_valid_q, bus.ms_gr_we, bus.ms_dest, bus.id_raddr2);
        hws1 = bus.id_use1 & hit(ws_valid_q, bus.ws_gr_we, bus.ws_dest, bus.id_raddr1);
        hws2 = bus.id_use2 & hit(ws_valid_q, bus.ws_gr_we, bus.ws_dest, bus.id_raddr2);
`ifdef PIPE_FWD_EN
        stall         = bus.es_res_from_mem & (hes1 | hes2) & ds_valid_q;
        bus.fwd_sel1  = hes1 ? 2'd1 : hms1 ? 2'd2 : hws1 ? 2'd3 : 2'd0;
        bus.fwd_sel2  = hes2 ? 2'd1 : hms2 ? 2'd2 : hws2 ? 2'd3 : 2'd0;
`else
        stall         = (hes1 | hes2 | hms1 | hms2 | hws1 | hws2) & ds_valid_q;
        bus.fwd_sel1  = 2'd0;
        bus.fwd_sel2  = 2'd0;
`endif
        ds_ready_go = !stall;
        ms_ready_go = !bus.mem_wait;
        // allowin chains upstream from WB, which always accepts
        ms_allowin  = !ms_valid_q | ms_ready_go;
        es_allowin  = !es_valid_q | ms_allowin;
        ds_allowin  = !ds_valid_q | (ds_ready_go & es_allowin);
        redirect    = !reset & bus.br_taken & ds_valid_q & ds_ready_go & es_allowin;
        fs_valid_d  = 1'b1;
        ds_valid_d  = ds_allowin ? fs_valid_q & !redirect : ds_valid_q;
        es_valid_d  = es_allowin ? ds_valid_q & ds_ready_go : es_valid_q;
        ms_valid_d  = ms_allowin ? es_valid_q : ms_valid_q;
        ws_valid_d  = ms_valid_q & ms_ready_go;
        stall_cnt_d = stall_cnt_q + CNT_W'(stall);
        bus.pc_we          = !reset & ds_allowin;
        bus.br_redirect    = redirect;
        bus.fs_to_ds_we    = !reset & ds_allowin;
        bus.ds_to_es_we    = !reset & es_allowin;
        bus.es_to_ms_we    = !reset & ms_allowin;
        bus.ms_to_ws_we    = !reset;
        bus.load_use_stall = stall;
        bus.ds_valid       = ds_valid_q;
        bus.es_valid       = es_valid_q;
        bus.ms_valid       = ms_valid_q;
        bus.ws_valid       = ws_valid_q;
        bus.stall_cnt      = stall_cnt_q;
    end

`ifndef PIPE_FWD_EN
    logic unused_load_flag;
    assign unused_load_flag = bus.es_res_from_mem;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_q  <= 1'b0;
            ds_valid_q  <= 1'b0;
            es_valid_q  <= 1'b0;
            ms_valid_q  <= 1'b0;
            ws_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            fs_valid_q  <= fs_valid_d;
            ds_valid_q  <= ds_valid_d;
            es_valid_q  <= es_valid_d;
            ms_valid_q  <= ms_valid_d;
            ws_valid_q  <= ws_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios for pipe_hazard_ctrl; expectations adapt to PIPE_FWD_EN.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;
`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.RA_W(5), .CNT_W(32)) bus ();
    pipe_hazard_ctrl #(.RA_W(5), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    logic [3:0] valids;
    logic [5:0] wes;
    assign valids = {bus.ds_valid, bus.es_valid, bus.ms_valid, bus.ws_valid};
    assign wes    = {bus.pc_we, bus.fs_to_ds_we, bus.ds_to_es_we, bus.es_to_ms_we, bus.ms_to_ws_we, bus.br_redirect};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        bus.id_raddr1 = '0; bus.id_raddr2 = '0; bus.id_use1 = 0; bus.id_use2 = 0;
        bus.br_taken = 0; bus.es_gr_we = 0; bus.es_dest = '0; bus.es_res_from_mem = 0;
        bus.ms_gr_we = 0; bus.ms_dest = '0; bus.ws_gr_we = 0; bus.ws_dest = '0; bus.mem_wait = 0;
    endtask

    task automatic refill;
        clear_in;
        repeat (4) step;
    endtask

    task automatic test_reset;
        reset = 1;
        clear_in;
        repeat (3) step;
        checks++; if (valids !== 4'b0000) begin failures++; $display("FAIL rst_valids got=%b exp=0000", valids); end
        checks++; if (wes !== 6'b000000) begin failures++; $display("FAIL rst_wes got=%b exp=000000", wes); end
        checks++; if (bus.stall_cnt !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", bus.stall_cnt); end
        reset = 0;
        #1;
        checks++; if (wes !== 6'b111110) begin failures++; $display("FAIL rel_wes got=%b exp=111110", wes); end
        repeat (4) step;
        checks++; if (valids !== 4'b1110) begin failures++; $display("FAIL fill4_valids got=%b exp=1110", valids); end
        step;
        checks++; if (valids !== 4'b1111) begin failures++; $display("FAIL fill5_valids got=%b exp=1111", valids); end
    endtask

    task automatic test_load_use;
        bus.es_gr_we = 1; bus.es_res_from_mem = 1; bus.es_dest = 5;
        bus.id_raddr1 = 5; bus.id_use1 = 1;
        #1;
        checks++; if (bus.load_use_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", bus.load_use_stall); end
        checks++; if (wes !== 6'b001110) begin failures++; $display("FAIL lu_wes got=%b exp=001110", wes); end
        step;
        exp_cnt++;
        checks++; if (valids !== 4'b1011) begin failures++; $display("FAIL lu_bubble got=%b exp=1011", valids); end
        checks++; if (bus.stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL lu_cnt1 got=%0d exp=%0d", bus.stall_cnt, exp_cnt); end
        bus.es_gr_we = 0; bus.es_res_from_mem = 0; bus.es_dest = 0;
        bus.ms_gr_we = 1; bus.ms_dest = 5;
        #1;
        checks++; if (bus.fwd_sel1 !== (FWD ? 2'd2 : 2'd0)) begin failures++; $display("FAIL lu_fwd1 got=%0d exp=%0d", bus.fwd_sel1, FWD ? 2 : 0); end
        checks++; if (bus.load_use_stall !== !FWD) begin failures++; $display("FAIL lu_after got=%b exp=%b", bus.load_use_stall, !FWD); end
`ifndef PIPE_FWD_EN
        step;
        exp_cnt++;
        bus.ms_gr_we = 0; bus.ws_gr_we = 1; bus.ws_dest = 5;
        #1;
        checks++; if (bus.load_use_stall !== 1'b1) begin failures++; $display("FAIL lu_ws_stall got=%b exp=1", bus.load_use_stall); end
        step;
        exp_cnt++;
        bus.ws_gr_we = 0;
        #1;
        checks++; if (bus.load_use_stall !== 1'b0) begin failures++; $display("FAIL lu_done got=%b exp=0", bus.load_use_stall); end
`endif
        checks++; if (bus.stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL lu_cnt got=%0d exp=%0d", bus.stall_cnt, exp_cnt); end
        refill;
    endtask

    task automatic test_forward;
        bus.es_gr_we = 1; bus.es_dest = 3; bus.ms_gr_we = 1; bus.ms_dest = 3;
        bus.id_raddr2 = 3; bus.id_use2 = 1;
        #1;
        checks++; if (bus.fwd_sel2 !== (FWD ? 2'd1 : 2'd0)) begin failures++; $display("FAIL fwd_ex_wins got=%0d exp=%0d", bus.fwd_sel2, FWD ? 1 : 0); end
        checks++; if (bus.load_use_stall !== !FWD) begin failures++; $display("FAIL fwd_ex_stall got=%b exp=%b", bus.load_use_stall, !FWD); end
        bus.id_use2 = 0;
        #1;
        checks++; if (bus.fwd_sel2 !== 2'd0) begin failures++; $display("FAIL fwd_unused got=%0d exp=0", bus.fwd_sel2); end
        checks++; if (bus.load_use_stall !== 1'b0) begin failures++; $display("FAIL fwd_unused_stall got=%b exp=0", bus.load_use_stall); end
        step;
        clear_in;
        bus.ws_gr_we = 1; bus.ws_dest = 9; bus.id_raddr1 = 9; bus.id_use1 = 1;
        #1;
        checks++; if (bus.fwd_sel1 !== (FWD ? 2'd3 : 2'd0)) begin failures++; $display("FAIL fwd_wb got=%0d exp=%0d", bus.fwd_sel1, FWD ? 3 : 0); end
        bus.ms_gr_we = 1; bus.ms_dest = 9;
        #1;
        checks++; if (bus.fwd_sel1 !== (FWD ? 2'd2 : 2'd0)) begin failures++; $display("FAIL fwd_mem_over_wb got=%0d exp=%0d", bus.fwd_sel1, FWD ? 2 : 0); end
        clear_in;
        step;
        bus.es_gr_we = 1; bus.es_dest = 0; bus.id_use1 = 1; bus.id_use2 = 1;
        #1;
        checks++; if ({bus.fwd_sel1, bus.fwd_sel2} !== 4'd0) begin failures++; $display("FAIL fwd_r0 got=%b exp=0000", {bus.fwd_sel1, bus.fwd_sel2}); end
        checks++; if (bus.load_use_stall !== 1'b0) begin failures++; $display("FAIL fwd_r0_stall got=%b exp=0", bus.load_use_stall); end
        clear_in;
        step;
    endtask

    task automatic test_interlock;
        bus.ms_gr_we = 1; bus.ms_dest = 7; bus.id_raddr1 = 7; bus.id_use1 = 1;
        #1;
        checks++; if (bus.load_use_stall !== !FWD) begin failures++; $display("FAIL il_stall got=%b exp=%b", bus.load_use_stall, !FWD); end
        checks++; if (bus.fwd_sel1 !== (FWD ? 2'd2 : 2'd0)) begin failures++; $display("FAIL il_fwd got=%0d exp=%0d", bus.fwd_sel1, FWD ? 2 : 0); end
`ifndef PIPE_FWD_EN
        step;
        exp_cnt++;
        bus.ms_gr_we = 0; bus.ws_gr_we = 1; bus.ws_dest = 7;
        #1;
        checks++; if (bus.load_use_stall !== 1'b1) begin failures++; $display("FAIL il_ws_stall got=%b exp=1", bus.load_use_stall); end
        step;
        exp_cnt++;
        bus.ws_gr_we = 0;
        #1;
        checks++; if ({bus.load_use_stall, bus.pc_we, bus.fwd_sel1} !== 4'b0100) begin failures++; $display("FAIL il_done got=%b exp=0100", {bus.load_use_stall, bus.pc_we, bus.fwd_sel1}); end
`endif
        checks++; if (bus.stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL il_cnt got=%0d exp=%0d", bus.stall_cnt, exp_cnt); end
        refill;
    endtask

    task automatic test_branch;
        bus.br_taken = 1;
        #1;
        checks++; if (wes !== 6'b111111) begin failures++; $display("FAIL br_wes got=%b exp=111111", wes); end
        step;
        clear_in;
        checks++; if (valids !== 4'b0111) begin failures++; $display("FAIL br_kill got=%b exp=0111", valids); end
        refill;
        bus.es_gr_we = 1; bus.es_res_from_mem = 1; bus.es_dest = 4;
        bus.id_raddr1 = 4; bus.id_use1 = 1; bus.br_taken = 1;
        #1;
        checks++; if ({bus.load_use_stall, bus.br_redirect} !== 2'b10) begin failures++; $display("FAIL br_stalled got=%b exp=10", {bus.load_use_stall, bus.br_redirect}); end
        step;
        exp_cnt++;
        bus.es_gr_we = 0; bus.es_res_from_mem = 0; bus.es_dest = 0;
        #1;
        checks++; if ({bus.load_use_stall, bus.br_redirect} !== 2'b01) begin failures++; $display("FAIL br_honored got=%b exp=01", {bus.load_use_stall, bus.br_redirect}); end
        step;
        clear_in;
        checks++; if (valids[3:2] !== 2'b01) begin failures++; $display("FAIL br_stall_kill got=%b exp=01", valids[3:2]); end
        checks++; if (bus.stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL br_cnt got=%0d exp=%0d", bus.stall_cnt, exp_cnt); end
        refill;
    endtask

    task automatic test_mem_wait;
        bus.mem_wait = 1;
        #1;
        checks++; if (wes !== 6'b000010) begin failures++; $display("FAIL mw_wes got=%b exp=000010", wes); end
        for (int i = 0; i < 4; i++) begin
            step;
            checks++; if (valids !== 4'b1110) begin failures++; $display("FAIL mw_hold%0d got=%b exp=1110", i, valids); end
            checks++; if (wes !== 6'b000010) begin failures++; $display("FAIL mw_wes%0d got=%b exp=000010", i, wes); end
        end
        bus.mem_wait = 0;
        #1;
        checks++; if (wes !== 6'b111110) begin failures++; $display("FAIL mw_resume got=%b exp=111110", wes); end
        step;
        checks++; if (valids !== 4'b1111) begin failures++; $display("FAIL mw_refill got=%b exp=1111", valids); end
    endtask

    task automatic test_reset_mid;
        bus.es_gr_we = 1; bus.es_res_from_mem = 1; bus.es_dest = 2;
        bus.id_raddr2 = 2; bus.id_use2 = 1; bus.br_taken = 1;
        #1;
        checks++; if (bus.stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL mid_cnt_pre got=%0d exp=%0d", bus.stall_cnt, exp_cnt); end
        reset = 1;
        #1;
        checks++; if (wes !== 6'b000000) begin failures++; $display("FAIL mid_wes got=%b exp=000000", wes); end
        step;
        reset = 0;
        clear_in;
        checks++; if (valids !== 4'b0000) begin failures++; $display("FAIL mid_valids got=%b exp=0000", valids); end
        checks++; if (bus.stall_cnt !== 32'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", bus.stall_cnt); end
    endtask

    initial begin
        test_reset;
        test_load_use;
        test_forward;
        test_interlock;
        test_branch;
        test_mem_wait;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage LoongArch core (IF/ID/EX/MEM/WB). Owns the per-stage valid bits and generates the allowin and ready-go handshakes between stages. Detects load-use hazards, selects RAW forwarding sources for ID operands, and cancels the wrong-path IF instruction on a taken branch resolved in ID. Keeps a stall-cycle counter for debug.

Parameters:
RA_W, 5, register address width
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_raddr1  in  RA_W  ID rj read address
id_raddr2  in  RA_W  ID rk/rd read address
id_use1  in  1  ID actually consumes raddr1
id_use2  in  1  ID actually consumes raddr2
br_taken  in  1  ID branch/jump taken (combinational from ID)
es_gr_we  in  1  EX instruction writes GPR
es_dest  in  RA_W  EX destination
es_res_from_mem  in  1  EX instruction is a load
ms_gr_we  in  1  MEM writes GPR
ms_dest  in  RA_W  MEM destination
ws_gr_we  in  1  WB writes GPR
ws_dest  in  RA_W  WB destination
mem_wait  in  1  data memory not ready; MEM must hold
pc_we  out  1  PC register may update
br_redirect  out  1  PC takes branch target this cycle
fs_to_ds_we  out  1  IF/ID pipeline register load
ds_to_es_we  out  1  ID/EX load
es_to_ms_we  out  1  EX/MEM load
ms_to_ws_we  out  1  MEM/WB load
ds_valid, es_valid, ms_valid, ws_valid  out  1 each  stage valid bits
fwd_sel1  out  2  rj source: 0 regfile, 1 EX, 2 MEM, 3 WB
fwd_sel2  out  2  rk/rd source, same encoding
load_use_stall  out  1  ID held by load-use hazard
stall_cnt  out  CNT_W  cycles with ds_valid & !ds_ready_go

Behaviour:
- Reset (sync, at clk edge with reset=1): fs_valid, ds_valid, es_valid, ms_valid, ws_valid = 0; stall_cnt = 0. All *_we outputs are 0 while reset=1. fs_valid goes to 1 on the first edge after reset deasserts.
- Ready-go: ds_ready_go = !load_use_stall; es_ready_go = 1; ms_ready_go = !mem_wait; ws_ready_go = 1.
- Allowin: ws_allowin = 1; X_allowin = !X_valid | (X_ready_go & next_allowin) for ms, es, ds; fs_allowin = ds_allowin.
- Register loads: fs_to_ds_we = ds_allowin; ds_to_es_we = es_allowin; es_to_ms_we = ms_allowin; ms_to_ws_we = ws_allowin.
- Valid updates: on ds_allowin, ds_valid <= fs_valid & !br_redirect. es_valid <= ds_valid & ds_ready_go when es_allowin. ms_valid <= es_valid when ms_allowin. ws_valid <= ms_valid & ms_ready_go.
- pc_we = !reset & fs_allowin. br_redirect = br_taken & ds_valid & ds_ready_go & es_allowin. The IF instruction fetched that cycle is killed: it enters ID invalid.
- Hazard match hX(a) = X_valid & X_gr_we & (X_dest != 0) & (X_dest == a), for X in es, ms, ws.
- load_use_stall = es_res_from_mem & ((id_use1 & hes(id_raddr1)) | (id_use2 & hes(id_raddr2))) & ds_valid. A load-use stall inserts one bubble: es_valid goes to 0.
- Forward priority is EX > MEM > WB. Address 0 is never forwarded (fwd_sel = 0). fwd_sel is meaningful only when id_useN = 1; otherwise it is 0.
- mem_wait = 1: ms, es and ds are all held, because allowin propagates upstream. ws_valid goes to 0 (bubble). fwd_sel still reflects the held stages.
- br_taken asserted while ID is stalled is ignored; it is honored in the cycle the stall clears.
- stall_cnt increments by 1 per cycle when ds_valid & !ds_ready_go, and wraps at 2^CNT_W.
- Reset asserted mid-operation: all valids clear on that edge, pending stalls and redirects are discarded, and stall_cnt clears.

Optional Feature:
PIPE_FWD_EN
- Defined: forwarding as above; only load-use stalls.
- Undefined: fwd_sel1 and fwd_sel2 are tied to 0. load_use_stall asserts on any hes, hms or hws match for a used operand (full RAW interlock). The port list is unchanged.

Test Plan:
- Reset for 3 cycles, then release: all valids 0 and pc_we=0 during reset. pc_we=1 and fs_to_ds_we=1 on the next cycle. ws_valid=1 on the 5th edge after release.
- EX valid load with es_dest=5; ID has id_raddr1=5, id_use1=1: load_use_stall=1, pc_we=0, es_valid=0 next cycle, stall_cnt=1. Next cycle fwd_sel1=2, no stall.
- EX add es_dest=3, MEM ms_dest=3, ID raddr2=3, id_use2=1: fwd_sel2=1 (EX wins). With es_dest=0 and raddr=0: fwd_sel=0.
- br_taken=1 with ds_valid=1 and no stall: br_redirect=1. ds_valid=0 next cycle (IF instruction killed), es_valid=1.
- mem_wait high for 4 cycles with all stages full: ds/es/ms valid held, ws_valid=0, pc_we=0, all *_we except ms_to_ws_we are 0. Pipeline resumes when mem_wait drops.
- PIPE_FWD_EN undefined, ms_dest=7 and ID raddr1=7: load_use_stall=1 until the instruction leaves WB (2 stall cycles), then stalling stops and fwd_sel1=0.
